// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU memory path and a
// DMA/program-loader port. Each access is sequenced IDLE -> ISSUE -> (WAIT) -> DONE.
// The CPU has priority, and a starvation counter forces a DMA grant after
// STARVE_MAX back-to-back CPU wins.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   cpu_req_i/we/addr/wdata  CPU request. The request is a level held until cpu_ack_o.
//   cpu_rdata_o           registered CPU read data. It loads in the DONE cycle.
//   cpu_ack_o             one-cycle completion pulse (DONE cycle)
//   cpu_stall_o           cpu_req_i & ~cpu_ack_o. The control unit holds its state while this is high.
//   dma_*                 same meaning as the cpu_* ports, for the DMA side (no stall)
//   mem_en_o/we/addr/wdata   RAM strobe and command. mem_en_o is high for the ISSUE cycle only.
//   mem_rdata_i           RAM read data, valid MEM_LAT cycles after mem_en_o
//   busy_o                FSM is not in IDLE
module mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int LAT_W = 3;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q;
  logic              owner_q;   // 1 = DMA owns the access in flight
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [ST_W-1:0]   starve_q;

  logic              starve_full;
  logic              grant_dma;
  logic [ST_W-1:0]   starve_d;

  // The DMA wins when it is the only requester, or when it has been passed
  // over STARVE_MAX times in a row.
  assign starve_full = (starve_q == ST_W'(STARVE_MAX));
  assign grant_dma   = dma_req_i & (~cpu_req_i | starve_full);

  // Starvation counter value to apply on a grant. It is only used in IDLE,
  // and only when a request is present.
  always_comb begin
    starve_d = starve_q;
    if (grant_dma) begin
      starve_d = '0;
    end else if (dma_req_i) begin
      starve_d = starve_full ? starve_q : starve_q + ST_W'(1);
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
    end else begin
      // The strobe and the acks are single-cycle pulses.
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req_i || dma_req_i) begin
            owner_q  <= grant_dma;
            we_q     <= grant_dma ? dma_we_i    : cpu_we_i;
            addr_q   <= grant_dma ? dma_addr_i  : cpu_addr_i;
            wdata_q  <= grant_dma ? dma_wdata_i : cpu_wdata_i;
            mem_en_q <= 1'b1;
            mem_we_q <= grant_dma ? dma_we_i : cpu_we_i;
            starve_q <= starve_d;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (MEM_LAT == 1) begin
            cpu_ack_q <= ~owner_q;
            dma_ack_q <= owner_q;
            state_q   <= S_DONE;
          end else begin
            lat_cnt_q <= LAT_W'(MEM_LAT - 1);
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The counter reaches 1 in the last WAIT cycle, so DONE lands
          // exactly MEM_LAT cycles after the strobe.
          if (lat_cnt_q == LAT_W'(1)) begin
            lat_cnt_q <= '0;
            cpu_ack_q <= ~owner_q;
            dma_ack_q <= owner_q;
            state_q   <= S_DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        S_DONE: begin
          // RAM data is valid in this cycle. It shows up on rdata in the following cycle.
          if (!we_q) begin
            if (owner_q) dma_rdata_q <= mem_rdata_i;
            else         cpu_rdata_q <= mem_rdata_i;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized CPU/DMA requesters and a RAM model.
// A spec-level reference model (shadow memory plus a grant schedule) pushes
// expected transactions. A separate monitor compares the DUT against them every cycle.
module tb_mem_arbiter;
  localparam int LAT    = 3;
  localparam int SMAX   = 4;
  localparam int BUDGET = 100;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [8:0]  cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int a);
    return (a == 'h010) ? 32'hDEADBEEF : {16'hC0DE, 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RAM model. Read data appears LAT cycles after the strobe; garbage at all other times.
  logic [31:0] ram [512];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = init_val(i);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : $urandom();
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // Reference model. Accesses are serialised, so one shadow memory gives
  // every read result. A request seen while free at cycle t is issued at t+1,
  // acked at t+1+LAT, and the arbiter is free again at t+2+LAT.
  typedef struct {
    bit          dma;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          issue;
    int          ack;
  } txn_t;
  txn_t q[$];

  initial begin : model
    logic [31:0] shadow [512];
    int starve, free_cyc;
    txn_t t;
    for (int i = 0; i < 512; i++) shadow[i] = init_val(i);
    starve = 0;
    free_cyc = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        starve = 0;
        free_cyc = cyc + 1;
      end else if (cyc >= free_cyc && (cpu_req || dma_req)) begin
        t.dma = dma_req && (!cpu_req || starve == SMAX);
        if (t.dma) starve = 0;
        else if (dma_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        else starve = 0;
        t.we    = t.dma ? dma_we : cpu_we;
        t.addr  = t.dma ? dma_addr : cpu_addr;
        t.wdata = t.dma ? dma_wdata : cpu_wdata;
        t.rdata = shadow[t.addr];
        if (t.we) shadow[t.addr] = t.wdata;
        t.issue = cyc + 1;
        t.ack   = cyc + 1 + LAT;
        q.push_back(t);
        free_cyc = cyc + 2 + LAT;
      end
      cyc++;
    end
  end

  // Monitor
  logic [31:0] exp_cpu_rd = 32'h0;
  logic [31:0] exp_dma_rd = 32'h0;
  bit          log_en = 1'b0;
  bit          ack_log[$];

  always @(negedge clk) begin : monitor
    txn_t t;
    bit en_e, we_e, ca_e, da_e, busy_e, have;
    have = (q.size() > 0);
    en_e = 0; we_e = 0; ca_e = 0; da_e = 0; busy_e = 0;
    if (have) begin
      t = q[0];
      en_e   = (t.issue == cyc);
      we_e   = en_e && t.we;
      ca_e   = (t.ack == cyc) && !t.dma;
      da_e   = (t.ack == cyc) && t.dma;
      busy_e = (cyc >= t.issue) && (cyc <= t.ack);
    end
    chk("mem_en", 32'(mem_en), 32'(en_e));
    chk("mem_we", 32'(mem_we), 32'(we_e));
    if (en_e) begin
      chk("mem_addr", 32'(mem_addr), 32'(t.addr));
      chk("mem_wdata", mem_wdata, t.wdata);
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(ca_e));
    chk("dma_ack", 32'(dma_ack), 32'(da_e));
    chk("ack_exclusive", 32'(cpu_ack & dma_ack), 32'h0);
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~ca_e));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("dma_rdata", dma_rdata, exp_dma_rd);
    if (log_en) begin
      if (cpu_ack) ack_log.push_back(1'b0);
      if (dma_ack) ack_log.push_back(1'b1);
    end
    if (have && t.ack == cyc) begin
      if (!t.we) begin
        if (t.dma) exp_dma_rd = t.rdata;
        else       exp_cpu_rd = t.rdata;
      end
      void'(q.pop_front());
    end
    if (rst) begin
      exp_cpu_rd = 32'h0;
      exp_dma_rd = 32'h0;
    end
  end

  // Requesters. Each is entered and left at posedge+1. With keep=1 the req
  // stays high across the ack edge, so the next call continues it seamlessly.
  task automatic cpu_txn(input bit we, input logic [8:0] a, input logic [31:0] d,
                         input bit early, input bit keep);
    bit got = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (early) begin
      @(posedge clk); #1 cpu_req = 1'b0;
    end
    for (int i = 0; i < (early ? 12 : BUDGET) && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
    end
    @(posedge clk); #1;
    if (!keep) cpu_req = 1'b0;
    if (!got && !early) begin
      checks++; fails++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack within %0d cycles", BUDGET);
    end
  endtask

  task automatic dma_txn(input bit we, input logic [8:0] a, input logic [31:0] d,
                         input bit early, input bit keep);
    bit got = 0;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    if (early) begin
      @(posedge clk); #1 dma_req = 1'b0;
    end
    for (int i = 0; i < (early ? 12 : BUDGET) && !got; i++) begin
      @(negedge clk);
      if (dma_ack) got = 1;
    end
    @(posedge clk); #1;
    if (!keep) dma_req = 1'b0;
    if (!got && !early) begin
      checks++; fails++;
      $display("FAIL dma_ack_timeout: got no ack expected ack within %0d cycles", BUDGET);
    end
  endtask

  function automatic logic [8:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 9'h010;
      1:       return 9'h1FF;
      default: return 9'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit pat [10];
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // CPU read of preloaded location
    cpu_txn(1'b0, 9'h010, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cpu_read_010", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // DMA write at top address, then CPU readback
    dma_txn(1'b1, 9'h1FF, 32'h12345678, 1'b0, 1'b0);
    cpu_txn(1'b0, 9'h1FF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cpu_read_1ff", cpu_rdata, 32'h12345678);
    @(posedge clk); #1;

    // One-cycle request pulse must still complete
    cpu_txn(1'b0, 9'h005, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("early_drop_rdata", cpu_rdata, init_val('h005));
    @(posedge clk); #1;

    // Continuous contention: expected order is C C C C D, repeated
    log_en = 1'b1;
    fork
      for (int k = 0; k < 8; k++) cpu_txn(1'b0, 9'(k), 32'h0, 1'b0, k != 7);
      for (int k = 0; k < 2; k++) dma_txn(1'b1, 9'(32 + k), 32'hD0D0_0000 + k, 1'b0, k != 1);
    join
    log_en = 1'b0;
    for (int i = 0; i < 10; i++) pat[i] = (i % 5 == 4);
    chk("contention_grant_count", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      chk($sformatf("contention_grant_%0d", i), 32'(ack_log[i]), 32'(pat[i]));

    // Reset while the read sits in WAIT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_in_wait", 32'(busy), 32'h1);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_ack", 32'(cpu_ack), 32'h0);
    chk("post_rst_rdata", cpu_rdata, 32'h0);
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic
    fork
      for (int k = 0; k < 40; k++) begin
        bit e;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #0;
        e = ($urandom_range(0, 7) == 0);
        cpu_txn(1'($urandom), rand_addr(), $urandom(), e, !e && ($urandom_range(0, 1) == 1) && k != 39);
      end
      for (int k = 0; k < 40; k++) begin
        bit e;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #0;
        e = ($urandom_range(0, 7) == 0);
        dma_txn(1'($urandom), rand_addr(), $urandom(), e, !e && ($urandom_range(0, 1) == 1) && k != 39);
      end
    join
    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
